// File: rtl/pwm_dac_pkg.sv
// Shared defaults and helpers for the PWM DAC stage of the SAR ADC.
package pwm_dac_pkg;

    localparam int unsigned DefWidth         = 8;
    localparam int unsigned DefPrescale      = 1;
    localparam int unsigned DefSettlePeriods = 16;

    // Counter must be able to hold the value SettlePeriods itself.
    function automatic int unsigned settle_cnt_width(input int unsigned periods);
        return $clog2(periods + 1);
    endfunction

endpackage

// File: rtl/pwm_dac_if.sv
// Code request handshake between the SAR controller (master) and the PWM DAC (slave).
interface pwm_dac_if import pwm_dac_pkg::*; #(
    parameter int unsigned Width = DefWidth
);
    logic [Width-1:0] code;
    logic             valid;
    logic             ready;

    modport master (output code, output valid, input ready);
    modport slave  (input code, input valid, output ready);
endinterface

// File: rtl/pwm_tick_gen.sv
// PWM tick prescaler: one tick every Prescale clocks while enabled.
module pwm_tick_gen import pwm_dac_pkg::*; #(
    parameter int unsigned Prescale = DefPrescale
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable_i,
    output logic tick_o
);
    localparam int unsigned          CntW   = (Prescale > 1) ? $clog2(Prescale) : 1;
    localparam logic [CntW-1:0]      CntMax = CntW'(Prescale - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = enable_i && (cnt_q == CntMax);
        cnt_d  = cnt_q;
        if (!enable_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/pwm_dac.sv
// PWM DAC: double-buffered duty code applied at period boundaries, with RC settle tracking.
module pwm_dac import pwm_dac_pkg::*; #(
    parameter int unsigned Width         = DefWidth,
    parameter int unsigned Prescale      = DefPrescale,
    parameter int unsigned SettlePeriods = DefSettlePeriods
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    pwm_dac_if.slave         code_if,
    output logic             pwm_out_o,
    output logic             period_start_o,
    output logic             settled_o,
    output logic [Width-1:0] active_code_o
);
    localparam int unsigned        SettleW   = settle_cnt_width(SettlePeriods);
    localparam logic [SettleW-1:0] SettleMax = SettleW'(SettlePeriods);

    logic               tick;
    logic               boundary, handshake, transfer;
    logic [Width-1:0]   phase_q, phase_d;
    logic [Width-1:0]   pend_code_q, pend_code_d;
    logic               pend_full_q, pend_full_d;
    logic [Width-1:0]   active_q, active_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic               pwm_q, pwm_d;
    logic               pstart_q, pstart_d;

    pwm_tick_gen #(
        .Prescale (Prescale)
    ) u_tick_gen (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .enable_i (enable_i),
        .tick_o   (tick)
    );

    always_comb begin
        boundary    = tick && (phase_q == '1);
        handshake   = code_if.valid && !pend_full_q;
        transfer    = boundary && pend_full_q;

        phase_d     = phase_q;
        pend_code_d = pend_code_q;
        pend_full_d = pend_full_q;
        active_d    = active_q;
        settle_d    = settle_q;
        pwm_d       = enable_i && (phase_q < active_q);
        pstart_d    = boundary;

        if (!enable_i) begin
            phase_d  = '0;
            settle_d = '0;
        end else begin
            if (tick) phase_d = phase_q + 1'b1;
            if (transfer) begin
                settle_d = '0;
            end else if (boundary && settle_q != SettleMax) begin
                settle_d = settle_q + 1'b1;
            end
        end

        // Handshake only happens with pending empty, so it never collides with a transfer.
        if (transfer) begin
            active_d    = pend_code_q;
            pend_full_d = 1'b0;
        end
        if (handshake) begin
            pend_code_d = code_if.code;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q     <= '0;
            pend_code_q <= '0;
            pend_full_q <= 1'b0;
            active_q    <= '0;
            settle_q    <= '0;
            pwm_q       <= 1'b0;
            pstart_q    <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            pend_code_q <= pend_code_d;
            pend_full_q <= pend_full_d;
            active_q    <= active_d;
            settle_q    <= settle_d;
            pwm_q       <= pwm_d;
            pstart_q    <= pstart_d;
        end
    end

    assign code_if.ready  = !pend_full_q;
    assign pwm_out_o      = pwm_q;
    assign period_start_o = pstart_q;
    assign settled_o      = (settle_q == SettleMax);
    assign active_code_o  = active_q;
endmodule

// File: tb/tb_pwm_dac.sv
// Bench for pwm_dac: two instances (fast and prescaled) against a time-based reference model.
module tb_pwm_dac;
    localparam int unsigned W   = 8;
    localparam int unsigned NPh = 1 << W;
    localparam int unsigned PA  = 1;
    localparam int unsigned SA  = 2;
    localparam int unsigned PB  = 4;
    localparam int unsigned SB  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         in_reset [2];
    logic         in_en    [2];
    logic         in_valid [2];
    logic [W-1:0] in_code  [2];

    pwm_dac_if #(.Width(W)) if_a ();
    pwm_dac_if #(.Width(W)) if_b ();
    assign if_a.valid = in_valid[0];
    assign if_a.code  = in_code[0];
    assign if_b.valid = in_valid[1];
    assign if_b.code  = in_code[1];

    logic         pwm_a, pst_a, set_a, pwm_b, pst_b, set_b;
    logic [W-1:0] act_a, act_b;

    pwm_dac #(.Width(W), .Prescale(PA), .SettlePeriods(SA)) u_dut_a (
        .clk_i          (clk),
        .reset_i        (in_reset[0]),
        .enable_i       (in_en[0]),
        .code_if        (if_a.slave),
        .pwm_out_o      (pwm_a),
        .period_start_o (pst_a),
        .settled_o      (set_a),
        .active_code_o  (act_a)
    );

    pwm_dac #(.Width(W), .Prescale(PB), .SettlePeriods(SB)) u_dut_b (
        .clk_i          (clk),
        .reset_i        (in_reset[1]),
        .enable_i       (in_en[1]),
        .code_if        (if_b.slave),
        .pwm_out_o      (pwm_b),
        .period_start_o (pst_b),
        .settled_o      (set_b),
        .active_code_o  (act_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: time since enable, one-deep pending slot, periods since transfer.
    int m_cyc [2];
    int m_act [2];
    int m_per [2];
    int m_pcode [2];
    bit m_pfull [2];
    bit m_pwm [2];
    bit m_pst [2];

    function automatic int prescale_of(input int idx);
        return (idx == 0) ? PA : PB;
    endfunction

    function automatic int settle_of(input int idx);
        return (idx == 0) ? SA : SB;
    endfunction

    function automatic bit boundary_next(input int idx);
        int p;
        p = prescale_of(idx);
        return in_en[idx] && (m_cyc[idx] % p == p - 1) && ((m_cyc[idx] / p) % NPh == NPh - 1);
    endfunction

    task automatic model_step(input int idx);
        bit hs, bnd, xfer;
        int p, phase;
        if (in_reset[idx]) begin
            m_cyc[idx] = 0; m_act[idx] = 0; m_per[idx] = 0;
            m_pfull[idx] = 0; m_pwm[idx] = 0; m_pst[idx] = 0;
            return;
        end
        p    = prescale_of(idx);
        hs   = in_valid[idx] && !m_pfull[idx];
        bnd  = boundary_next(idx);
        xfer = bnd && m_pfull[idx];
        if (in_en[idx]) begin
            phase      = (m_cyc[idx] / p) % NPh;
            m_pwm[idx] = (phase < m_act[idx]);
            m_pst[idx] = bnd;
            if (xfer) m_per[idx] = 0;
            else if (bnd && m_per[idx] < settle_of(idx)) m_per[idx]++;
            m_cyc[idx]++;
        end else begin
            m_cyc[idx] = 0; m_per[idx] = 0; m_pwm[idx] = 0; m_pst[idx] = 0;
        end
        if (xfer) begin
            m_act[idx]   = m_pcode[idx];
            m_pfull[idx] = 0;
        end
        if (hs) begin
            m_pcode[idx] = int'(in_code[idx]);
            m_pfull[idx] = 1;
        end
    endtask

    function automatic logic o_pwm(input int idx);  return idx == 0 ? pwm_a : pwm_b;          endfunction
    function automatic logic o_pst(input int idx);  return idx == 0 ? pst_a : pst_b;          endfunction
    function automatic logic o_set(input int idx);  return idx == 0 ? set_a : set_b;          endfunction
    function automatic logic o_rdy(input int idx);  return idx == 0 ? if_a.ready : if_b.ready; endfunction
    function automatic logic [W-1:0] o_act(input int idx); return idx == 0 ? act_a : act_b;   endfunction

    task automatic compare(input int idx);
        check_eq($sformatf("pwm_out[%0d]", idx), o_pwm(idx), m_pwm[idx]);
        check_eq($sformatf("period_start[%0d]", idx), o_pst(idx), m_pst[idx]);
        check_eq($sformatf("settled[%0d]", idx), o_set(idx), m_per[idx] == settle_of(idx));
        check_eq($sformatf("code_ready[%0d]", idx), o_rdy(idx), !m_pfull[idx]);
        check_eq($sformatf("active_code[%0d]", idx), o_act(idx), m_act[idx]);
    endtask

    task automatic tick_clk();
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        compare(0);
        compare(1);
    endtask

    task automatic send_code(input int idx, input logic [W-1:0] code);
        bit acc, done;
        done = 0;
        in_code[idx]  = code;
        in_valid[idx] = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            acc = o_rdy(idx);
            tick_clk();
            if (acc) begin
                done = 1;
                break;
            end
        end
        in_valid[idx] = 1'b0;
        check_eq($sformatf("handshake_done[%0d]", idx), done, 1);
    endtask

    task automatic wait_pst(input int idx);
        bit found;
        found = 0;
        for (int i = 0; i < 3000; i++) begin
            tick_clk();
            if (o_pst(idx)) begin
                found = 1;
                break;
            end
        end
        check_eq($sformatf("period_start_seen[%0d]", idx), found, 1);
    endtask

    task automatic count_high(input int idx, input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            c += int'(o_pwm(idx));
            tick_clk();
        end
    endtask

    int  c;
    bit  found;
    int  r;

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_reset[i] = 1'b1; in_en[i] = 1'b0; in_valid[i] = 1'b0; in_code[i] = '0;
            m_pcode[i] = 0;
        end
        tick_clk();
        tick_clk();
        check_eq("rst_ready", if_a.ready, 1);
        check_eq("rst_active", act_a, 0);
        check_eq("rst_pwm", pwm_a, 0);
        in_reset[0] = 1'b0;
        in_reset[1] = 1'b0;
        in_en[0]    = 1'b1;

        send_code(0, 8'd64);
        check_eq("ready_drop", if_a.ready, 0);
        wait_pst(0);
        check_eq("act64", act_a, 64);
        count_high(0, 256, c);
        check_eq("high64", c, 64);
        check_eq("pst_period", pst_a, 1);

        send_code(0, 8'd0);
        wait_pst(0);
        count_high(0, 256, c);
        check_eq("high0", c, 0);
        send_code(0, 8'd255);
        wait_pst(0);
        count_high(0, 256, c);
        check_eq("high255", c, 255);

        send_code(0, 8'd128);
        wait_pst(0);
        check_eq("settle_xfer", set_a, 0);
        wait_pst(0);
        check_eq("settle_b1", set_a, 0);
        wait_pst(0);
        check_eq("settle_b2", set_a, 1);
        send_code(0, 8'd128);
        wait_pst(0);
        check_eq("resettle_drop", set_a, 0);
        wait_pst(0);
        wait_pst(0);
        check_eq("resettle_rise", set_a, 1);

        // Second request while the pending slot is full must stall.
        wait_pst(0);
        send_code(0, 8'd200);
        in_code[0]  = 8'd33;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick_clk();
            check_eq("no_accept_ready", if_a.ready, 0);
        end
        in_valid[0] = 1'b0;
        wait_pst(0);
        check_eq("no_accept_act", act_a, 200);

        // Handshake landing exactly on a boundary with pending empty.
        found = 0;
        for (int i = 0; i < 600; i++) begin
            if (boundary_next(0)) begin
                found = 1;
                break;
            end
            tick_clk();
        end
        check_eq("bnd_found", found, 1);
        in_code[0]  = 8'd77;
        in_valid[0] = 1'b1;
        tick_clk();
        in_valid[0] = 1'b0;
        check_eq("bnd_hs_hold", act_a, 200);
        check_eq("bnd_hs_taken", if_a.ready, 0);
        wait_pst(0);
        check_eq("bnd_hs_apply", act_a, 77);

        repeat (100) tick_clk();
        in_en[0] = 1'b0;
        repeat (3) tick_clk();
        check_eq("dis_pwm", pwm_a, 0);
        check_eq("dis_settled", set_a, 0);
        in_en[0] = 1'b1;
        repeat (50) tick_clk();
        in_reset[0] = 1'b1;
        tick_clk();
        check_eq("mid_rst_ready", if_a.ready, 1);
        check_eq("mid_rst_act", act_a, 0);
        check_eq("mid_rst_settled", set_a, 0);
        in_reset[0] = 1'b0;

        in_en[1] = 1'b1;
        send_code(1, 8'd10);
        wait_pst(1);
        count_high(1, 4 * NPh, c);
        check_eq("b_high40", c, 40);
        check_eq("b_period", pst_b, 1);

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                in_reset[i] = ($urandom_range(0, 599) == 0);
                if ($urandom_range(0, 299) == 0) in_en[i] = ~in_en[i];
                in_valid[i] = ($urandom_range(0, 3) == 0);
                r = int'($urandom_range(0, 9));
                in_code[i] = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : W'($urandom);
            end
            tick_clk();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
